audio_mixer_sd: RTL and testbench

AUDIO_MIXER_SD -- requirements
Module: audio_mixer_sd

---
 rtl/audio_mixer_sd_pkg.sv | 17 +
 rtl/audio_mixer_sd_sd_dac.sv | 37 +++
 rtl/audio_mixer_sd.sv | 206 ++++++++++++++++++++
 tb/tb_audio_mixer_sd.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_mixer_sd_pkg.sv
// Shared definitions for the audio mixer: FSM state encoding and gain constants.
package audio_mixer_sd_pkg;

    // Mixer sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_CLAMP = 2'd2
    } mix_state_t;

    // Gain code that passes a channel through unchanged.
    localparam logic [3:0] UNITY_GAIN = 4'd8;

    // Right shift applied to the accumulated mix so that UNITY_GAIN maps to x1.
    localparam int GAIN_SHIFT = 3;

endpackage

// File: rtl/audio_mixer_sd_sd_dac.sv
// First-order sigma-delta DAC with excess-2^OW input coding.
// The sigma latch MSB feeds back as a subtraction of 2^OW, so the ones
// density of the bitstream equals sample / 2^OW.
module sd_dac_ow #(
    parameter int OW = 10
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [OW-1:0] sample,
    output logic          dac_out
);

    localparam int SW = OW + 2;
    localparam logic [SW-1:0] SIGMA_RESET = {2'b10, {OW{1'b0}}};

    logic [SW-1:0] sigma_r;
    logic [SW-1:0] delta_s;
    logic [SW-1:0] sigma_next_s;

    // Delta adder folds the MSB feedback into the input; sigma adder integrates it.
    always_comb begin
        delta_s      = {2'b00, sample} + {sigma_r[SW-1], sigma_r[SW-1], {OW{1'b0}}};
        sigma_next_s = delta_s + sigma_r;
    end

    // Sigma latch and the registered output bit taken from its MSB.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sigma_r <= SIGMA_RESET;
            dac_out <= 1'b0;
        end else begin
            sigma_r <= sigma_next_s;
            dac_out <= sigma_r[SW-1];
        end
    end

endmodule

// File: rtl/audio_mixer_sd.sv
// Stereo multi-channel mixer: snapshots NCH samples per side on a tick,
// accumulates gain-weighted channels one per cycle, saturates the result
// to OW bits and drives one sigma-delta DAC per side.
module audio_mixer_sd
    import audio_mixer_sd_pkg::*;
#(
    parameter int NCH = 4,
    parameter int IW  = 8,
    parameter int OW  = 10
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              sample_tick,
    input  logic [NCH*IW-1:0] ch_l,
    input  logic [NCH*IW-1:0] ch_r,
    input  logic [NCH*4-1:0]  gain,
    output logic              audio_left,
    output logic              audio_right,
    output logic              busy,
    output logic              clip_l,
    output logic              clip_r,
    output logic              overrun
);

    localparam int AW   = IW + 4 + $clog2(NCH);
    localparam int PW   = IW + 4;
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW   = (AW > OW) ? AW : OW + 1;
    localparam logic [CW-1:0]   MIX_MAX  = {{(CW-OW){1'b0}}, {OW{1'b1}}};
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCH - 1);

    mix_state_t        state_r;
    mix_state_t        state_next_s;
    logic [IDXW-1:0]   idx_r;
    logic [AW-1:0]     acc_l_r;
    logic [AW-1:0]     acc_r_r;
    logic [NCH*IW-1:0] shadow_l_r;
    logic [NCH*IW-1:0] shadow_r_r;
    logic [NCH*4-1:0]  shadow_g_r;
    logic [OW-1:0]     sample_l_r;
    logic [OW-1:0]     sample_r_r;
    logic              clip_l_r;
    logic              clip_r_r;
    logic              overrun_r;
    logic              busy_r;

    logic              load_s;
    logic              accum_s;
    logic              clamp_s;
    logic              overrun_set_s;

    logic [IW-1:0]     sel_l_s;
    logic [IW-1:0]     sel_r_s;
    logic [3:0]        sel_g_s;
    logic [PW-1:0]     prod_l_s;
    logic [PW-1:0]     prod_r_s;

    logic [CW-1:0]     mix_l_s;
    logic [CW-1:0]     mix_r_s;
    logic [OW-1:0]     clamp_l_s;
    logic [OW-1:0]     clamp_r_s;
    logic              over_l_s;
    logic              over_r_s;

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and control strobes; a tick outside IDLE only raises overrun.
    always_comb begin
        state_next_s  = state_r;
        load_s        = 1'b0;
        accum_s       = 1'b0;
        clamp_s       = 1'b0;
        overrun_set_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (sample_tick) begin
                    load_s       = 1'b1;
                    state_next_s = ST_ACCUM;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                accum_s       = 1'b1;
                overrun_set_s = sample_tick;
                if (idx_r == IDX_LAST) begin
                    state_next_s = ST_CLAMP;
                end else begin
                    state_next_s = ST_ACCUM;
                end
            end
            ST_CLAMP: begin
                clamp_s       = 1'b1;
                overrun_set_s = sample_tick;
                state_next_s  = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Select the current shadow channel and its gain and form both products.
    always_comb begin
        sel_l_s  = shadow_l_r[int'(idx_r)*IW +: IW];
        sel_r_s  = shadow_r_r[int'(idx_r)*IW +: IW];
        sel_g_s  = shadow_g_r[int'(idx_r)*4 +: 4];
        prod_l_s = PW'(sel_l_s) * PW'(sel_g_s);
        prod_r_s = PW'(sel_r_s) * PW'(sel_g_s);
    end

    // Scale the accumulators down by the gain shift and saturate to OW bits.
    always_comb begin
        mix_l_s = CW'(acc_l_r) >> GAIN_SHIFT;
        mix_r_s = CW'(acc_r_r) >> GAIN_SHIFT;
        if (mix_l_s > MIX_MAX) begin
            clamp_l_s = {OW{1'b1}};
            over_l_s  = 1'b1;
        end else begin
            clamp_l_s = mix_l_s[OW-1:0];
            over_l_s  = 1'b0;
        end
        if (mix_r_s > MIX_MAX) begin
            clamp_r_s = {OW{1'b1}};
            over_r_s  = 1'b1;
        end else begin
            clamp_r_s = mix_r_s[OW-1:0];
            over_r_s  = 1'b0;
        end
    end

    // Datapath: snapshot, accumulate, clamp into the DAC sample registers, flags.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            idx_r      <= {IDXW{1'b0}};
            acc_l_r    <= {AW{1'b0}};
            acc_r_r    <= {AW{1'b0}};
            shadow_l_r <= {(NCH*IW){1'b0}};
            shadow_r_r <= {(NCH*IW){1'b0}};
            shadow_g_r <= {NCH{UNITY_GAIN}};
            sample_l_r <= {OW{1'b0}};
            sample_r_r <= {OW{1'b0}};
            clip_l_r   <= 1'b0;
            clip_r_r   <= 1'b0;
            overrun_r  <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            if (load_s) begin
                shadow_l_r <= ch_l;
                shadow_r_r <= ch_r;
                shadow_g_r <= gain;
                acc_l_r    <= {AW{1'b0}};
                acc_r_r    <= {AW{1'b0}};
                idx_r      <= {IDXW{1'b0}};
            end else if (accum_s) begin
                acc_l_r <= acc_l_r + AW'(prod_l_s);
                acc_r_r <= acc_r_r + AW'(prod_r_s);
                if (idx_r == IDX_LAST) begin
                    idx_r <= {IDXW{1'b0}};
                end else begin
                    idx_r <= idx_r + IDXW'(1);
                end
            end else if (clamp_s) begin
                sample_l_r <= clamp_l_s;
                sample_r_r <= clamp_r_s;
                clip_l_r   <= over_l_s;
                clip_r_r   <= over_r_s;
            end else begin
                idx_r <= idx_r;
            end
            if (overrun_set_s) begin
                overrun_r <= 1'b1;
            end else begin
                overrun_r <= overrun_r;
            end
            busy_r <= (state_next_s != ST_IDLE);
        end
    end

    sd_dac_ow #(.OW(OW)) u_dac_left (
        .Clk     (Clk),
        .Reset   (Reset),
        .sample  (sample_l_r),
        .dac_out (audio_left)
    );

    sd_dac_ow #(.OW(OW)) u_dac_right (
        .Clk     (Clk),
        .Reset   (Reset),
        .sample  (sample_r_r),
        .dac_out (audio_right)
    );

    assign busy    = busy_r;
    assign clip_l  = clip_l_r;
    assign clip_r  = clip_r_r;
    assign overrun = overrun_r;

endmodule

// File: tb/tb_audio_mixer_sd.sv
// Scoreboard bench for audio_mixer_sd (NCH=4, IW=8, OW=10).
// Accepted ticks push an expected mix; a monitor pops it when busy falls and
// checks the clip flags; DAC outputs are checked by ones density.
module tb_audio_mixer_sd;

    localparam int NCH = 4;
    localparam int IW  = 8;
    localparam int OW  = 10;
    localparam int FULL = 1 << OW;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              sample_tick;
    logic [NCH*IW-1:0] ch_l;
    logic [NCH*IW-1:0] ch_r;
    logic [NCH*4-1:0]  gain;
    logic              audio_left;
    logic              audio_right;
    logic              busy;
    logic              clip_l;
    logic              clip_r;
    logic              overrun;

    typedef struct {
        int samp_l;
        int samp_r;
        int clip_l;
        int clip_r;
    } exp_t;

    exp_t exp_q[$];
    int   exp_cur_l = 0;
    int   exp_cur_r = 0;
    int   checks    = 0;
    int   failures  = 0;

    audio_mixer_sd #(.NCH(NCH), .IW(IW), .OW(OW)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .sample_tick (sample_tick),
        .ch_l        (ch_l),
        .ch_r        (ch_r),
        .gain        (gain),
        .audio_left  (audio_left),
        .audio_right (audio_right),
        .busy        (busy),
        .clip_l      (clip_l),
        .clip_r      (clip_r),
        .overrun     (overrun)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: weighted sum of channels, divided by 8, saturated to 2^OW-1.
    function automatic void ref_side(input logic [NCH*IW-1:0] chs, input logic [NCH*4-1:0] g,
                                     output int samp, output int clip);
        int s;
        s = 0;
        for (int k = 0; k < NCH; k++) begin
            s += int'(chs[k*IW +: IW]) * int'(g[k*4 +: 4]);
        end
        s = s / 8;
        clip = (s > FULL - 1) ? 1 : 0;
        samp = (s > FULL - 1) ? FULL - 1 : s;
    endfunction

    function automatic exp_t ref_mix(input logic [NCH*IW-1:0] l, input logic [NCH*IW-1:0] r,
                                     input logic [NCH*4-1:0] g);
        exp_t e;
        ref_side(l, g, e.samp_l, e.clip_l);
        ref_side(r, g, e.samp_r, e.clip_r);
        return e;
    endfunction

    // Drive a one-cycle tick with new data; the accepted mix is queued.
    task automatic issue_tick(input logic [NCH*IW-1:0] l, input logic [NCH*IW-1:0] r,
                              input logic [NCH*4-1:0] g);
        @(posedge Clk); #1;
        ch_l = l; ch_r = r; gain = g; sample_tick = 1'b1;
        exp_q.push_back(ref_mix(l, r, g));
        @(posedge Clk); #1;
        sample_tick = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        bit done;
        n = 0;
        done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge Clk);
            if (busy) n++;
            else done = 1'b1;
        end
        if (!done) check("idle_timeout", n, 0);
    endtask

    task automatic density(input string name);
        int ones_l, ones_r;
        repeat (2048) @(posedge Clk);
        ones_l = 0;
        ones_r = 0;
        repeat (FULL) begin
            @(negedge Clk);
            ones_l += int'(audio_left);
            ones_r += int'(audio_right);
        end
        check({name, "_left_ones"}, ones_l, exp_cur_l);
        check({name, "_right_ones"}, ones_r, exp_cur_r);
    endtask

    // Monitor: a completed mix shows as busy falling outside reset.
    initial begin
        bit   prev_busy;
        exp_t e;
        prev_busy = 1'b0;
        forever begin
            @(negedge Clk);
            if (!Reset && prev_busy && !busy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_mix", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("clip_l", int'(clip_l), e.clip_l);
                    check("clip_r", int'(clip_r), e.clip_r);
                    exp_cur_l = e.samp_l;
                    exp_cur_r = e.samp_r;
                end
            end
            prev_busy = busy;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [NCH*IW-1:0] rl, rr;
        logic [NCH*4-1:0]  rg;

        Reset = 1'b1; sample_tick = 1'b0;
        ch_l = '0; ch_r = '0; gain = '0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst_busy", int'(busy), 0);
        check("rst_clip_l", int'(clip_l), 0);
        check("rst_clip_r", int'(clip_r), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_audio_left", int'(audio_left), 0);
        check("rst_audio_right", int'(audio_right), 0);
        @(posedge Clk); #1;
        Reset = 1'b0;

        // Unity gain: 4 x 100 -> 400 left, 4 x 50 -> 200 right.
        issue_tick(32'h64646464, 32'h32323232, 16'h8888);
        wait_idle(n);
        check("busy_cycles", n, NCH + 1);
        density("unity");

        // Full scale saturates both sides, then zeros release the clips.
        issue_tick(32'hFFFFFFFF, 32'hFFFFFFFF, 16'hFFFF);
        wait_idle(n);
        density("saturate");
        issue_tick(32'h00000000, 32'h00000000, 16'hFFFF);
        wait_idle(n);
        density("zero");

        // Steady 256 on the left, 512 on the right.
        issue_tick(32'h40404040, 32'h80808080, 16'h8888);
        wait_idle(n);
        density("quarter");

        // A tick in the first IDLE cycle after CLAMP is accepted.
        rl = $urandom; rr = $urandom; rg = 16'($urandom);
        issue_tick(rl, rr, rg);
        repeat (NCH + 1) @(posedge Clk);
        #1;
        rl = $urandom; rr = $urandom; rg = 16'($urandom);
        ch_l = rl; ch_r = rr; gain = rg; sample_tick = 1'b1;
        exp_q.push_back(ref_mix(rl, rr, rg));
        @(posedge Clk); #1;
        sample_tick = 1'b0;
        wait_idle(n);
        check("b2b_busy_cycles", n, NCH + 1);
        check("b2b_overrun", int'(overrun), 0);
        density("back_to_back");

        // Tick at cycle 3 of a mix is dropped and raises a sticky overrun.
        issue_tick(32'h14141414, 32'h1E1E1E1E, 16'h8888);
        repeat (2) @(posedge Clk);
        #1;
        ch_l = 32'hFFFFFFFF; ch_r = 32'hFFFFFFFF; gain = 16'hFFFF; sample_tick = 1'b1;
        @(posedge Clk); #1;
        sample_tick = 1'b0;
        @(negedge Clk);
        check("overrun_set", int'(overrun), 1);
        wait_idle(n);
        density("overrun_mix");
        check("overrun_sticky", int'(overrun), 1);
        @(posedge Clk); #1;
        Reset = 1'b1;
        exp_cur_l = 0; exp_cur_r = 0;
        @(posedge Clk); #1;
        check("overrun_cleared", int'(overrun), 0);
        Reset = 1'b0;

        // Reset at cycle 2 of a mix abandons it.
        issue_tick(32'h64646464, 32'h64646464, 16'h8888);
        @(posedge Clk); #1;
        Reset = 1'b1;
        exp_q.delete();
        @(posedge Clk);
        @(negedge Clk);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_audio_left", int'(audio_left), 0);
        check("mid_rst_audio_right", int'(audio_right), 0);
        @(posedge Clk); #1;
        Reset = 1'b0;
        exp_cur_l = 0; exp_cur_r = 0;
        density("after_reset");

        // Independent sides: right ch0=200 at g0=4 -> 100; left ch0=80 -> 40.
        issue_tick(32'h77777750, 32'h000000C8, 16'h0004);
        wait_idle(n);
        density("sides");

        // Random mixes; clips checked on every mix, density on a few.
        for (int i = 0; i < 16; i++) begin
            rl = $urandom; rr = $urandom; rg = 16'($urandom);
            if (i % 4 == 1) rg = 16'($urandom_range(0, 65535) & 32'h00007777);
            issue_tick(rl, rr, rg);
            wait_idle(n);
            check("rand_busy_cycles", n, NCH + 1);
            if (i % 6 == 0) density("random");
        end

        @(negedge Clk);
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
